axi_rd_arbiter: RTL and testbench
=================================

# axi_rd_arbiter

Two-requester read-channel arbiter that shares the single AXI AR/R port to main memory between the instruction cache (port 0) and the data cache (port 1). It grants one requester per burst with round-robin priority and keeps exactly one read burst outstanding. It forwards the granted requester's AR handshake to the memory side and steers every R beat back to that requester. It sits between the two cache refill engines and the AXI memory interface.

## Interface
Parameters:
- `ADDR_W`, 32: AR address width.
- `DATA_W`, 32: R data width.
- `ID_W`, 4: AXI ID width. Must be ≥ 1.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `s_arid` in 2×`ID_W`: per-requester AR ID (index 0 = icache, 1 = dcache).
- `s_araddr` in 2×`ADDR_W`: per-requester AR address.
- `s_arvalid` in 2: per-requester AR request.
- `s_arready` out 2: per-requester AR accept.
- `s_rid` out 2×`ID_W`: per-requester returned ID; equals the requester's latched `s_arid`.
- `s_rdata` out 2×`DATA_W`: per-requester read data.
- `s_rlast` out 2: per-requester last beat.
- `s_rvalid` out 2: per-requester beat valid.
- `s_rready` in 2: per-requester beat accept.
- `m_arid` out `ID_W`: memory-side AR ID; equals the grant index, zero-extended.
- `m_araddr` out `ADDR_W`: memory-side AR address.
- `m_arvalid` out 1: memory-side AR request.
- `m_arready` in 1: memory-side AR accept.
- `m_rid` in `ID_W`: memory-side R ID.
- `m_rdata` in `DATA_W`: memory-side R data.
- `m_rlast` in 1: memory-side last beat.
- `m_rvalid` in 1: memory-side beat valid.
- `m_rready` out 1: memory-side beat accept.
- `err` out 1: sticky protocol-error flag.

## Operation
- FSM states: IDLE, AR, R.
- **IDLE**
  - If any `s_arvalid` is high, pick the winner:
    - Both requesting: the winner is the port not equal to `last_gnt`.
    - One requesting: that port wins.
  - Latch `gnt`, `s_araddr[gnt]` and `s_arid[gnt]`, then go to AR.
  - No memory-side outputs are asserted in IDLE.
- **AR**
  - `m_arvalid`=1, `m_araddr`=latched address, `m_arid`=`gnt`.
  - `s_arready[gnt]` = `m_arready`. The other `s_arready` stays 0.
  - On `m_arvalid & m_arready`, go to R.
  - The address is held from the latch. A requester dropping `s_arvalid` after grant does not cancel the burst.
- **R**
  - `m_rready` = `s_rready[gnt]`.
  - `s_rvalid[gnt]` = `m_rvalid`. `s_rdata[gnt]` and `s_rlast[gnt]` pass through.
  - `s_rid[gnt]` = latched ID.
  - The non-granted port sees `s_rvalid`=0.
  - On `m_rvalid & m_rready & m_rlast`: set `last_gnt`←`gnt` and go to IDLE.
- **Error flag:** `err` is set, and stays set until reset, when either:
  - `m_rvalid` is high outside state R, or
  - in R, `m_rvalid` is high with `m_rid` ≠ `gnt`.
- Beats counted as errors are still forwarded in R. They are not accepted outside R (`m_rready`=0).
- Bursts of any length are supported, including a single beat with `rlast` on the first beat.

## Timing
- **Reset values**
  - State IDLE, `gnt`=0, `last_gnt`=1 (port 0 wins the first tie), `err`=0.
  - Every `s_arready`, `s_rvalid`, `s_rlast`=0; `m_arvalid`=0, `m_rready`=0.
  - `m_araddr`=0, `m_arid`=0.
- **Reset mid-burst:** the arbiter returns to IDLE on the next edge and discards the burst. The system resets the memory side simultaneously.
- **Latency**
  - `s_arvalid` sampled high in IDLE at edge N gives `m_arvalid`=1 in cycle N+1.
  - The AR handshake completes in the same cycle `m_arready` is seen.
  - R-path steering is combinational, with zero added latency per beat.
- **Back-to-back:** after the last-beat handshake at edge M, state is IDLE in cycle M+1. The next grant's `m_arvalid` rises in cycle M+2, giving a 1-cycle bubble.
- **Simultaneous events:** a new `s_arvalid` arriving during the last R beat is served only after the return to IDLE.
- **Fairness:** with both ports requesting continuously, grants alternate 0,1,0,1.
- `m_arvalid`, once raised, stays high until `m_arready`, as AXI requires.

## Structure
- Shared package `axi_pkg`:
  - FSM state enum (`ARB_IDLE`, `ARB_AR`, `ARB_R`).
  - Requester index constants `REQ_ICACHE`=0 and `REQ_DCACHE`=1.
  - Default width constants.
- One sub-module, `rr_pick2`: the combinational 2-way round-robin chooser. Inputs: request vector and `last_gnt`. Outputs: `any` and `winner`.
- The remainder (FSM, latches, steering muxes, error flag) stays in `axi_rd_arbiter`.

## Test plan
- **Single request:** port 1 requests addr 0x0000_1A40, id 3.
  - `m_arvalid` rises one cycle later with `m_araddr`=0x1A40 and `m_arid`=1.
  - 8 beats with `m_rid`=1 reach port 1 only, with `s_rid[1]`=3. `err` stays 0.
- **Tie and fairness:** both ports hold `s_arvalid` from reset for 4 bursts.
  - Grant order is 0,1,0,1.
  - Each next `m_arvalid` rises exactly 2 cycles after the prior last-beat handshake.
- **AR backpressure:** `m_arready` is held low for 5 cycles.
  - `m_arvalid` and `m_araddr` stay stable.
  - `s_arready[gnt]` pulses only in the accept cycle.
- **R backpressure:** the granted requester drops `s_rready` on beat 3 for 2 cycles.
  - `m_rready` follows it.
  - No beat is lost or duplicated; the data sequence 0..7 arrives in order.
- **Protocol error:**
  - `m_rvalid` asserted in IDLE sets `err`=1, and `err` stays 1 through later clean bursts.
  - A separate run with `m_rid`=0 during a port-1 burst also sets `err`.
- **Mid-burst reset:** `reset` is asserted after beat 4.
  - Next cycle: IDLE, all valids 0, `last_gnt`=1.
  - The first post-reset tie is granted to port 0.

Source files
------------

// File: rtl/axi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_pkg : shared types and constants for the AXI read-channel arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
package axi_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_AR   = 2'd1,
    ARB_R    = 2'd2
  } arb_state_e;

  localparam logic REQ_ICACHE = 1'b0;
  localparam logic REQ_DCACHE = 1'b1;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ID_W   = 4;

endpackage
`default_nettype wire

// File: rtl/axi_rd_arbiter_rr_pick2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick2 : combinational 2-way round-robin chooser
// Revision: 1.0
// ---------------------------------------------------------------------------
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_gnt_i,
  output logic       any_o,
  output logic       winner_o
);

  assign any_o    = |req_i;
  // On a tie the port that did not win last time goes next.
  assign winner_o = (&req_i) ? ~last_gnt_i : req_i[1];

endmodule
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_rd_arbiter : shares one AXI AR/R port between icache (0) and dcache (1)
// Revision: 1.0
// ---------------------------------------------------------------------------
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ID_W   = DEF_ID_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2*ID_W-1:0]     s_arid,
  input  logic [2*ADDR_W-1:0]   s_araddr,
  input  logic [1:0]            s_arvalid,
  output logic [1:0]            s_arready,
  output logic [2*ID_W-1:0]     s_rid,
  output logic [2*DATA_W-1:0]   s_rdata,
  output logic [1:0]            s_rlast,
  output logic [1:0]            s_rvalid,
  input  logic [1:0]            s_rready,
  output logic [ID_W-1:0]       m_arid,
  output logic [ADDR_W-1:0]     m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [ID_W-1:0]       m_rid,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic                  err
);

  arb_state_e          state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                last_gnt_q, last_gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                err_q, err_d;
  logic                w_any;
  logic                w_winner;

  rr_pick2 u_pick (
    .req_i      (s_arvalid),
    .last_gnt_i (last_gnt_q),
    .any_o      (w_any),
    .winner_o   (w_winner)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    addr_d     = addr_q;
    id_d       = id_q;
    case (state_q)
      ARB_IDLE: begin
        if (w_any) begin
          gnt_d   = w_winner;
          state_d = ARB_AR;
          if (w_winner == REQ_DCACHE) begin
            addr_d = s_araddr[2*ADDR_W-1:ADDR_W];
            id_d   = s_arid[2*ID_W-1:ID_W];
          end else begin
            addr_d = s_araddr[ADDR_W-1:0];
            id_d   = s_arid[ID_W-1:0];
          end
        end
      end
      ARB_AR: begin
        if (m_arready) state_d = ARB_R;
      end
      ARB_R: begin
        if (m_rvalid && m_rready && m_rlast) begin
          last_gnt_d = gnt_q;
          state_d    = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    // Stray beats outside a burst or with a foreign ID are flagged until reset.
    err_d = err_q | (m_rvalid && ((state_q != ARB_R) || (m_rid != ID_W'(gnt_q))));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= REQ_ICACHE;
      last_gnt_q <= REQ_DCACHE;
      addr_q     <= '0;
      id_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      id_q       <= id_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    s_arready = '0;
    s_rid     = '0;
    s_rdata   = '0;
    s_rlast   = '0;
    s_rvalid  = '0;
    m_arid    = '0;
    m_araddr  = '0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    if (state_q == ARB_AR) begin
      m_arvalid        = 1'b1;
      m_araddr         = addr_q;
      m_arid           = ID_W'(gnt_q);
      s_arready[gnt_q] = m_arready;
    end
    if (state_q == ARB_R) begin
      m_rready        = s_rready[gnt_q];
      s_rvalid[gnt_q] = m_rvalid;
      s_rlast[gnt_q]  = m_rlast;
      if (gnt_q == REQ_DCACHE) begin
        s_rdata[2*DATA_W-1:DATA_W] = m_rdata;
        s_rid[2*ID_W-1:ID_W]       = id_q;
      end else begin
        s_rdata[DATA_W-1:0] = m_rdata;
        s_rid[ID_W-1:0]     = id_q;
      end
    end
  end

  assign err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axi_rd_arbiter : directed + randomized bench with a burst-level model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_axi_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic            clk;
  logic            reset;
  logic [2*IW-1:0] s_arid;
  logic [2*AW-1:0] s_araddr;
  logic [1:0]      s_arvalid;
  logic [1:0]      s_arready;
  logic [2*IW-1:0] s_rid;
  logic [2*DW-1:0] s_rdata;
  logic [1:0]      s_rlast;
  logic [1:0]      s_rvalid;
  logic [1:0]      s_rready;
  logic [IW-1:0]   m_arid;
  logic [AW-1:0]   m_araddr;
  logic            m_arvalid;
  logic            m_arready;
  logic [IW-1:0]   m_rid;
  logic [DW-1:0]   m_rdata;
  logic            m_rlast;
  logic            m_rvalid;
  logic            m_rready;
  logic            err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int mlast    = 1;
  int last_hs  = 0;
  bit exp_err  = 1'b0;
  logic [AW-1:0] addr_v [2];
  logic [IW-1:0] id_v   [2];

  axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .reset(reset),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: a lone requester wins; on a tie the previous loser wins.
  function automatic int pick(input logic [1:0] req, input int last);
    if (req == 2'b11) return 1 - last;
    return req[1] ? 1 : 0;
  endfunction

  task automatic set_req(input int p);
    addr_v[p] = $urandom;
    id_v[p]   = IW'($urandom_range(0, 15));
    s_araddr[p*AW +: AW] = addr_v[p];
    s_arid[p*IW +: IW]   = id_v[p];
  endtask

  task automatic pulse_reset(input logic [1:0] req);
    reset = 1'b1; s_arvalid = req; m_arready = 1'b0; m_rvalid = 1'b0;
    m_rlast = 1'b0; s_rready = 2'b00; m_rid = '0; m_rdata = '0;
    tick(); tick();
    reset = 1'b0; mlast = 1; exp_err = 1'b0;
  endtask

  // Plays one burst as the memory side; returns at +3 in the cycle after the last beat.
  task automatic do_burst(input int port, input logic [AW-1:0] addr, input logic [IW-1:0] id,
                          input int nb, input int arw, input int stall_at, input int stall_len,
                          input bit bad_rid, input int rst_after, input int ref_cyc,
                          input int gap, input bit drop);
    int seen, b, stall_rem, budget;
    logic [DW-1:0] base;
    logic [DW-1:0] rxq [$];
    logic [1:0] onehot;
    logic [AW-1:0] held;
    bit hs;
    onehot = 2'b01 << port;
    seen = -1;
    for (int i = 0; i < 8; i++) begin
      #2;
      if (m_arvalid) begin seen = cyc; break; end
      tick();
    end
    if (seen < 0) begin
      #2;
      chk("ar_timeout", 64'd0, 64'd1);
      return;
    end
    if (gap >= 0) chk("ar_latency", 64'(seen - ref_cyc), 64'(gap));
    chk("m_arid", 64'(m_arid), 64'(port));
    chk("m_araddr", 64'(m_araddr), 64'(addr));
    if (drop) begin
      s_arvalid[port] = 1'b0;
      s_araddr[port*AW +: AW] = ~addr;
    end
    held = addr;
    for (int w = 0; w < arw; w++) begin
      m_arready = 1'b0;
      #1;
      chk("ar_hold_valid", 64'(m_arvalid), 64'd1);
      chk("ar_hold_addr", 64'(m_araddr), 64'(held));
      chk("ar_early_ready", 64'(s_arready), 64'd0);
      tick();
      #2;
    end
    m_arready = 1'b1;
    #1;
    chk("s_arready", 64'(s_arready), 64'(onehot));
    tick();
    m_arready = 1'b0;

    base = $urandom;
    b = 0;
    stall_rem = stall_len;
    budget = nb + stall_len + 4;
    while (b < nb && budget > 0) begin
      budget--;
      m_rvalid = 1'b1;
      m_rdata  = base + DW'(b);
      m_rlast  = (b == nb - 1);
      m_rid    = bad_rid ? IW'(1 - port) : IW'(port);
      s_rready = 2'b00;
      s_rready[1-port] = 1'($urandom_range(0, 1));
      if (b == stall_at && stall_rem > 0) stall_rem--;
      else s_rready[port] = 1'b1;
      #2;
      chk("s_rvalid", 64'(s_rvalid), 64'(onehot));
      chk("m_rready", 64'(m_rready), 64'(s_rready[port]));
      chk("s_rid", 64'(s_rid[port*IW +: IW]), 64'(id));
      chk("s_rlast", 64'(s_rlast), m_rlast ? 64'(onehot) : 64'd0);
      if (s_rvalid[port] && s_rready[port]) rxq.push_back(s_rdata[port*DW +: DW]);
      hs = m_rready;
      if (bad_rid) exp_err = 1'b1;
      if (hs) begin
        if (b == nb - 1) last_hs = cyc;
        b++;
      end
      tick();
      if (rst_after > 0 && hs && b == rst_after) begin
        reset = 1'b1; m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 2'b00;
        tick();
        #2;
        chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
        chk("rst_s_rvalid", 64'(s_rvalid), 64'd0);
        chk("rst_m_rready", 64'(m_rready), 64'd0);
        chk("rst_s_arready", 64'(s_arready), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        reset = 1'b0; mlast = 1; exp_err = 1'b0;
        return;
      end
    end
    if (b < nb) chk("r_timeout", 64'(b), 64'(nb));
    m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 2'b00;
    chk("beat_count", 64'(rxq.size()), 64'(nb));
    for (int i = 0; i < rxq.size() && i < nb; i++)
      chk("beat_data", 64'(rxq[i]), 64'(base + DW'(i)));
    #2;
    chk("err", 64'(err), 64'(exp_err));
    mlast = port;
  endtask

  initial begin
    int p;
    logic [1:0] pend, newreq;
    reset = 1'b1; s_arid = '0; s_araddr = '0; s_arvalid = 2'b00; s_rready = 2'b00;
    m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    tick(); tick();
    #2;
    chk("rst_s_arready", 64'(s_arready), 64'd0);
    chk("rst_s_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_s_rlast", 64'(s_rlast), 64'd0);
    chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_m_rready", 64'(m_rready), 64'd0);
    chk("rst_m_araddr", 64'(m_araddr), 64'd0);
    chk("rst_m_arid", 64'(m_arid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    tick();
    reset = 1'b0;

    // Single request from the dcache
    s_araddr[2*AW-1:AW] = 32'h0000_1A40;
    s_arid[2*IW-1:IW]   = 4'd3;
    s_arvalid = 2'b10;
    do_burst(1, 32'h0000_1A40, 4'd3, 8, 0, -1, 0, 1'b0, 0, cyc, 1, 1'b1);
    tick();

    // AR backpressure on an icache request
    set_req(0);
    s_arvalid = 2'b01;
    p = pick(s_arvalid, mlast);
    do_burst(p, addr_v[p], id_v[p], 4, 5, -1, 0, 1'b0, 0, cyc, 1, 1'b1);
    tick();

    // R backpressure: stall beat 3 for two cycles
    set_req(1);
    s_arvalid = 2'b10;
    p = pick(s_arvalid, mlast);
    do_burst(p, addr_v[p], id_v[p], 8, 0, 3, 2, 1'b0, 0, cyc, 1, 1'b1);
    tick();

    // Tie from reset, four bursts
    set_req(0); set_req(1);
    pulse_reset(2'b11);
    for (int k = 0; k < 4; k++) begin
      p = pick(2'b11, mlast);
      do_burst(p, addr_v[p], id_v[p], int'($urandom_range(1, 4)), 0, -1, 0, 1'b0, 0,
               last_hs, (k == 0) ? -1 : 2, 1'b0);
      if (k == 3) s_arvalid = 2'b00;
      tick();
    end

    // Stray beat in IDLE sets the sticky error
    m_rvalid = 1'b1; m_rid = '0;
    #2;
    chk("idle_m_rready", 64'(m_rready), 64'd0);
    chk("idle_s_rvalid", 64'(s_rvalid), 64'd0);
    tick();
    m_rvalid = 1'b0;
    #2;
    chk("err_set_idle", 64'(err), 64'd1);
    exp_err = 1'b1;
    tick();
    set_req(0);
    s_arvalid = 2'b01;
    do_burst(0, addr_v[0], id_v[0], 3, 0, -1, 0, 1'b0, 0, cyc, 1, 1'b1);
    tick();

    // Wrong m_rid during a dcache burst
    pulse_reset(2'b00);
    #2;
    chk("err_cleared", 64'(err), 64'd0);
    tick();
    set_req(1);
    s_arvalid = 2'b10;
    do_burst(1, addr_v[1], id_v[1], 2, 0, -1, 0, 1'b1, 0, cyc, 1, 1'b1);
    tick();

    // Mid-burst reset after beat 4, then first tie must go to port 0
    pulse_reset(2'b00);
    set_req(0);
    s_arvalid = 2'b01;
    do_burst(0, addr_v[0], id_v[0], 1, 0, -1, 0, 1'b0, 0, cyc, 1, 1'b1);
    tick();
    set_req(1);
    s_arvalid = 2'b10;
    do_burst(1, addr_v[1], id_v[1], 8, 0, -1, 0, 1'b0, 4, cyc, 1, 1'b1);
    tick();
    set_req(0); set_req(1);
    s_arvalid = 2'b11;
    p = pick(s_arvalid, mlast);
    do_burst(p, addr_v[p], id_v[p], 2, 0, -1, 0, 1'b0, 0, cyc, 1, 1'b1);
    tick();
    p = pick(s_arvalid, mlast);
    do_burst(p, addr_v[p], id_v[p], 2, 0, -1, 0, 1'b0, 0, last_hs, 2, 1'b1);
    tick();

    // Randomized request mix against the round-robin model
    pend = 2'b00;
    for (int n = 0; n < 10; n++) begin
      newreq = 2'($urandom_range(0, 3));
      if ((pend | newreq) == 2'b00) newreq = 2'b01 << $urandom_range(0, 1);
      for (int q = 0; q < 2; q++)
        if (newreq[q] && !pend[q]) set_req(q);
      pend = pend | newreq;
      s_arvalid = pend;
      p = pick(pend, mlast);
      do_burst(p, addr_v[p], id_v[p], int'($urandom_range(1, 8)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 1'b0, 0, 0, -1, 1'b1);
      pend[p] = 1'b0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
